fetch_unit: RTL and testbench

//  Instruction-fetch stage directly downstream of the PC register. Takes the current pc/pc_p4,

---
 rtl/fetch_unit_pkg.sv | 21 ++
 rtl/fetch_unit_if_id_reg.sv | 51 +++++
 rtl/fetch_unit.sv | 105 ++++++++++
 tb/tb_fetch_unit.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage types and constants.
// IF/ID bundle, fetch FSM states, NOP bubble.
package fetch_unit_pkg;
  localparam int XLEN = 32;
  typedef logic [XLEN-1:0] data_t;
  localparam data_t NULL = '0;
  localparam data_t NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    F_REQ,
    F_WAIT,
    F_DRAIN
  } fetch_state_t;

  typedef struct packed {
    data_t instr;
    data_t pc;
    data_t pc_p4;
    logic  misalign;
  } if_id_t;
endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register.
// Load beats consume; flush beats load.
module if_id_reg
  import fetch_unit_pkg::*;
#(
  parameter data_t NOP = NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            flush,
  input  logic            consume,
  input  logic [XLEN-1:0] d_instr,
  input  logic [XLEN-1:0] d_pc,
  input  logic [XLEN-1:0] d_pc_p4,
  input  logic            d_misalign,
  output logic            valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_p4,
  output logic            misalign
);

  if_id_t q;

  // entry update: reset, then flush, load, consume
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= 1'b0;
      q     <= '{instr: NOP, pc: NULL,
                 pc_p4: NULL, misalign: 1'b0};
    end else if (flush) begin
      valid      <= 1'b0;
      q.instr    <= NOP;
      q.misalign <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= '{instr: d_instr, pc: d_pc,
                 pc_p4: d_pc_p4,
                 misalign: d_misalign};
    end else if (consume && valid) begin
      valid <= 1'b0;
    end
  end

  assign instr    = q.instr;
  assign pc       = q.pc;
  assign pc_p4    = q.pc_p4;
  assign misalign = q.misalign;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one imem read in flight,
// IF/ID register out, PC stall and redirect drain.
module fetch_unit #(
  parameter logic [fetch_unit_pkg::XLEN-1:0]
    NOP_INSTR = fetch_unit_pkg::NOP_INSTR,
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [fetch_unit_pkg::XLEN-1:0] pc,
  input  logic [fetch_unit_pkg::XLEN-1:0] pc_p4,
  input  logic                            flush,
  output logic                            imem_req_valid,
  input  logic                            imem_req_ready,
  output logic [fetch_unit_pkg::XLEN-1:0] imem_addr,
  input  logic                            imem_resp_valid,
  output logic                            imem_resp_ready,
  input  logic [fetch_unit_pkg::XLEN-1:0] imem_resp_data,
  output logic                            if_valid,
  input  logic                            if_ready,
  output logic [fetch_unit_pkg::XLEN-1:0] if_instr,
  output logic [fetch_unit_pkg::XLEN-1:0] if_pc,
  output logic [fetch_unit_pkg::XLEN-1:0] if_pc_p4,
  output logic                            if_misalign,
  output logic                            pc_stall
);
  import fetch_unit_pkg::*;

  fetch_state_t state, state_n;

  logic  out_free;
  logic  misal;
  logic  load;
  logic  ld_mis;
  data_t ld_instr;

  assign out_free  = ~if_valid | if_ready;
  assign misal     = CHECK_ALIGN & (|pc[1:0]);
  assign imem_addr = pc;

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= F_REQ;
    else        state <= state_n;
  end

  // next state, handshakes and output-register load
  always_comb begin
    state_n         = state;
    imem_req_valid  = 1'b0;
    imem_resp_ready = 1'b0;
    load            = 1'b0;
    ld_mis          = 1'b0;
    ld_instr        = imem_resp_data;
    if (rst_n) begin
      unique case (state)
        F_REQ: begin
          imem_req_valid = out_free & ~flush & ~misal;
          if (imem_req_valid && imem_req_ready)
            state_n = F_WAIT;
          if (misal && out_free && !flush) begin
            load     = 1'b1;
            ld_instr = NOP_INSTR;
            ld_mis   = 1'b1;
          end
        end
        F_WAIT: begin
          imem_resp_ready = out_free;
          if (imem_resp_valid && out_free) begin
            load    = ~flush;
            state_n = F_REQ;
          end else if (flush) begin
            state_n = F_DRAIN;
          end
        end
        F_DRAIN: begin
          imem_resp_ready = 1'b1;
          if (imem_resp_valid) state_n = F_REQ;
        end
        default: state_n = F_REQ;
      endcase
    end
  end

  // hold PC until an entry lands or a redirect arrives
  assign pc_stall = ~rst_n | ~(load | flush);

  if_id_reg #(.NOP(NOP_INSTR)) u_if_id (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .flush      (flush),
    .consume    (if_ready),
    .d_instr    (ld_instr),
    .d_pc       (pc),
    .d_pc_p4    (pc_p4),
    .d_misalign (ld_mis),
    .valid      (if_valid),
    .instr      (if_instr),
    .pc         (if_pc),
    .pc_p4      (if_pc_p4),
    .misalign   (if_misalign)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a PC
// register model and a delayed-response memory.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc;
  logic [31:0] pc_p4;
  logic        flush;
  logic [31:0] target;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_resp_valid;
  logic        imem_resp_ready;
  logic [31:0] imem_resp_data;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_p4;
  logic        if_misalign;
  logic        pc_stall;

  int n_cmp;
  int n_err;

  logic        pend;
  logic [31:0] maddr;
  int          cnt;
  int          delay;

  fetch_unit dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .pc              (pc),
    .pc_p4           (pc_p4),
    .flush           (flush),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_addr       (imem_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_ready (imem_resp_ready),
    .imem_resp_data  (imem_resp_data),
    .if_valid        (if_valid),
    .if_ready        (if_ready),
    .if_instr        (if_instr),
    .if_pc           (if_pc),
    .if_pc_p4        (if_pc_p4),
    .if_misalign     (if_misalign),
    .pc_stall        (pc_stall)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // PC register: advance or redirect when not stalled
  assign pc_p4 = pc + 32'd4;
  always @(posedge clk) begin
    if (!rst_n)         pc <= 32'h0;
    else if (!pc_stall) pc <= flush ? target : pc_p4;
  end

  // memory: data = C0DE_0000 | addr after delay cycles
  assign imem_resp_valid = pend && (cnt == 0);
  assign imem_resp_data  = 32'hC0DE_0000 | maddr;
  always @(posedge clk) begin
    if (!rst_n) begin
      pend  <= 1'b0;
      cnt   <= 0;
      maddr <= 32'h0;
    end else if (imem_req_valid && imem_req_ready) begin
      pend  <= 1'b1;
      maddr <= imem_addr;
      cnt   <= delay;
    end else if (imem_resp_valid && imem_resp_ready) begin
      pend <= 1'b0;
    end else if (pend && cnt != 0) begin
      cnt <= cnt - 1;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h want %h",
             tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (if_valid !== 1'b1 && n < 40) begin
      cyc();
      n++;
    end
    chk(tag, {31'd0, if_valid}, 32'd1);
  endtask

  task automatic wait_req(input logic [31:0] a);
    int n = 0;
    while (!(imem_req_valid === 1'b1 &&
             imem_addr === a) && n < 40) begin
      cyc();
      n++;
    end
    chk("wait_req", imem_addr, a);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    flush = 1'b0;
    target = 32'h0;
    if_ready = 1'b1;
    imem_req_ready = 1'b1;
    delay = 0;
    repeat (3) cyc();

    chk("rst_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_instr", if_instr, 32'h13);
    chk("rst_pc", if_pc, 32'h0);
    chk("rst_pc_p4", if_pc_p4, 32'h0);
    chk("rst_mis", {31'd0, if_misalign}, 32'd0);
    chk("rst_req", {31'd0, imem_req_valid}, 32'd0);
    chk("rst_rrdy", {31'd0, imem_resp_ready}, 32'd0);
    chk("rst_stall", {31'd0, pc_stall}, 32'd1);

    // 1: zero-wait stream, one entry per 2 cycles
    rst_n = 1'b1;
    #1;
    chk("t1_req0", {31'd0, imem_req_valid}, 32'd1);
    chk("t1_addr0", imem_addr, 32'h0);
    chk("t1_stall0", {31'd0, pc_stall}, 32'd1);
    cyc();
    chk("t1_wait_req", {31'd0, imem_req_valid}, 32'd0);
    chk("t1_rrdy", {31'd0, imem_resp_ready}, 32'd1);
    chk("t1_nostall", {31'd0, pc_stall}, 32'd0);
    cyc();
    chk("t1_v0", {31'd0, if_valid}, 32'd1);
    chk("t1_pc0", if_pc, 32'h0);
    chk("t1_p40", if_pc_p4, 32'h4);
    chk("t1_i0", if_instr, 32'hC0DE_0000);
    chk("t1_addr4", imem_addr, 32'h4);
    cyc();
    chk("t1_gap", {31'd0, if_valid}, 32'd0);
    cyc();
    chk("t1_pc4", if_pc, 32'h4);
    chk("t1_i4", if_instr, 32'hC0DE_0004);
    cyc();
    cyc();
    chk("t1_pc8", if_pc, 32'h8);
    chk("t1_i8", if_instr, 32'hC0DE_0008);
    cyc();
    cyc();
    chk("t1_pcC", if_pc, 32'hC);

    // 2: response for 0x10 delayed 3 cycles
    delay = 3;
    cyc();
    delay = 0;
    for (int i = 0; i < 3; i++) begin
      chk("t2_stall", {31'd0, pc_stall}, 32'd1);
      chk("t2_pc", pc, 32'h10);
      chk("t2_addr", imem_addr, 32'h10);
      cyc();
    end
    chk("t2_rel", {31'd0, pc_stall}, 32'd0);
    cyc();
    chk("t2_v", {31'd0, if_valid}, 32'd1);
    chk("t2_ipc", if_pc, 32'h10);
    chk("t2_i", if_instr, 32'hC0DE_0010);

    // 3: decode back-pressure for 5 cycles
    if_ready = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("t3_req", {31'd0, imem_req_valid}, 32'd0);
      chk("t3_rrdy", {31'd0, imem_resp_ready}, 32'd0);
      chk("t3_v", {31'd0, if_valid}, 32'd1);
      chk("t3_ipc", if_pc, 32'h10);
      chk("t3_stall", {31'd0, pc_stall}, 32'd1);
      cyc();
    end
    if_ready = 1'b1;

    // 4: flush while waiting on 0x20
    wait_req(32'h20);
    delay = 2;
    cyc();
    delay = 0;
    flush = 1'b1;
    target = 32'h100;
    #1;
    chk("t4_fstall", {31'd0, pc_stall}, 32'd0);
    cyc();
    flush = 1'b0;
    #1;
    chk("t4_v", {31'd0, if_valid}, 32'd0);
    chk("t4_i", if_instr, 32'h13);
    chk("t4_drain_req", {31'd0, imem_req_valid}, 32'd0);
    chk("t4_drain_rrdy", {31'd0, imem_resp_ready}, 32'd1);
    chk("t4_stall", {31'd0, pc_stall}, 32'd1);
    wait_valid("t4_tmo");
    chk("t4_ipc", if_pc, 32'h100);
    chk("t4_ii", if_instr, 32'hC0DE_0100);

    // 5: flush coincides with response handshake
    wait_req(32'h104);
    cyc();
    flush = 1'b1;
    target = 32'h200;
    #1;
    chk("t5_rrdy", {31'd0, imem_resp_ready}, 32'd1);
    cyc();
    flush = 1'b0;
    #1;
    chk("t5_v", {31'd0, if_valid}, 32'd0);
    chk("t5_nodrain", {31'd0, imem_req_valid}, 32'd1);
    chk("t5_addr", imem_addr, 32'h200);
    wait_valid("t5_tmo");
    chk("t5_ipc", if_pc, 32'h200);
    chk("t5_i", if_instr, 32'hC0DE_0200);

    // 6: redirect to a misaligned address
    flush = 1'b1;
    target = 32'h102;
    #1;
    chk("t6_freq", {31'd0, imem_req_valid}, 32'd0);
    cyc();
    flush = 1'b0;
    #1;
    chk("t6_req", {31'd0, imem_req_valid}, 32'd0);
    chk("t6_load", {31'd0, pc_stall}, 32'd0);
    cyc();
    chk("t6_v", {31'd0, if_valid}, 32'd1);
    chk("t6_mis", {31'd0, if_misalign}, 32'd1);
    chk("t6_i", if_instr, 32'h13);
    chk("t6_ipc", if_pc, 32'h102);
    chk("t6_p4", if_pc_p4, 32'h106);
    chk("t6_req2", {31'd0, imem_req_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
